// File: rtl/sa_mac_seq.sv
// sa_mac_seq: time-shares one saturating signed MAC to compute
// sat(bias + sum(sat(act_i * weight_i))) over a streamed operand sequence.
// Operands arrive on a valid/ready stream; the result leaves on a
// valid/ready port together with a sticky "any clamp occurred" flag.

// Combinational saturating MAC: clamp(acc + clamp(act * weight)).
module sa_mac #(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 16
) (
  input  logic signed [MUL_DATAWIDTH-1:0] act,
  input  logic signed [MUL_DATAWIDTH-1:0] weight,
  input  logic signed [ADD_DATAWIDTH-1:0] acc,
  output logic signed [ADD_DATAWIDTH-1:0] sum
);

  localparam int M = MUL_DATAWIDTH;
  localparam int A = ADD_DATAWIDTH;

  logic signed [2*M-1:0] prod_full_s;
  logic signed [M-1:0]   prod_clamp_s;
  logic signed [A:0]     sum_wide_s;

  // Full-width product, product clamp, widened add and final clamp.
  always_comb begin
    prod_full_s  = $signed({{M{act[M-1]}}, act}) * $signed({{M{weight[M-1]}}, weight});
    prod_clamp_s = prod_full_s[M-1:0];
    sum_wide_s   = {(A+1){1'b0}};
    sum          = {A{1'b0}};
    // Upper M+1 bits must all match the sign for the product to fit.
    if ((&prod_full_s[2*M-1:M-1]) || !(|prod_full_s[2*M-1:M-1])) begin
      prod_clamp_s = prod_full_s[M-1:0];
    end else if (prod_full_s[2*M-1]) begin
      prod_clamp_s = {1'b1, {(M-1){1'b0}}};
    end else begin
      prod_clamp_s = {1'b0, {(M-1){1'b1}}};
    end
    sum_wide_s = {acc[A-1], acc} + {{(A-M+1){prod_clamp_s[M-1]}}, prod_clamp_s};
    // One bit of headroom: the two top bits differ only on overflow.
    if (sum_wide_s[A] == sum_wide_s[A-1]) begin
      sum = sum_wide_s[A-1:0];
    end else if (sum_wide_s[A]) begin
      sum = {1'b1, {(A-1){1'b0}}};
    end else begin
      sum = {1'b0, {(A-1){1'b1}}};
    end
  end

endmodule

// Sequencer wrapping the MAC with a start/operand/result handshake FSM.
module sa_mac_seq #(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 16,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [LEN_WIDTH-1:0]     i_len,
  input  logic [ADD_DATAWIDTH-1:0] i_bias,
  output logic                     o_busy,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [MUL_DATAWIDTH-1:0] i_act,
  input  logic [MUL_DATAWIDTH-1:0] i_weight,
  output logic [ADD_DATAWIDTH-1:0] o_result,
  output logic                     o_result_valid,
  input  logic                     i_result_ready,
  output logic                     o_sat
);

  localparam int M = MUL_DATAWIDTH;
  localparam int A = ADD_DATAWIDTH;
  localparam int L = LEN_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [L-1:0] LEN_ZERO = {L{1'b0}};
  localparam logic [L-1:0] LEN_ONE  = {{(L-1){1'b0}}, 1'b1};

  logic [1:0]    state_r;
  logic [A-1:0]  acc_r;
  logic [L-1:0]  count_r;
  logic          sat_r;

  logic [A-1:0]  mac_sum_s;
  logic          accept_s;
  logic          step_sat_s;
  logic [2*M-1:0] chk_prod_s;
  logic [M-1:0]  chk_prod_clamp_s;
  logic [A:0]    chk_sum_s;

  sa_mac #(
    .MUL_DATAWIDTH (M),
    .ADD_DATAWIDTH (A)
  ) u_mac (
    .act    (i_act),
    .weight (i_weight),
    .acc    (acc_r),
    .sum    (mac_sum_s)
  );

  // Operand handshake and clamp detection for the step being accepted.
  always_comb begin
    accept_s         = (state_r == ST_ACCUM) && i_valid;
    chk_prod_s       = $signed({{M{i_act[M-1]}}, i_act}) * $signed({{M{i_weight[M-1]}}, i_weight});
    chk_prod_clamp_s = chk_prod_s[M-1:0];
    step_sat_s       = 1'b0;
    if ((&chk_prod_s[2*M-1:M-1]) || !(|chk_prod_s[2*M-1:M-1])) begin
      chk_prod_clamp_s = chk_prod_s[M-1:0];
    end else begin
      // Product does not fit; use the saturated value for the add stage.
      chk_prod_clamp_s = chk_prod_s[2*M-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
      step_sat_s       = 1'b1;
    end
    chk_sum_s = {acc_r[A-1], acc_r} + {{(A-M+1){chk_prod_clamp_s[M-1]}}, chk_prod_clamp_s};
    if (chk_sum_s[A] != chk_sum_s[A-1]) begin
      step_sat_s = 1'b1;
    end else begin
      step_sat_s = step_sat_s;
    end
  end

  // Control FSM plus accumulator, remaining count and sticky clamp flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      acc_r   <= {A{1'b0}};
      count_r <= LEN_ZERO;
      sat_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            count_r <= i_len;
            acc_r   <= i_bias;
            sat_r   <= 1'b0;
            state_r <= (i_len != LEN_ZERO) ? ST_ACCUM : ST_HOLD;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r   <= mac_sum_s;
            count_r <= count_r - LEN_ONE;
            sat_r   <= sat_r | step_sat_s;
            // Leaving at count 1 means the count never reaches a wrap.
            if (count_r == LEN_ONE) begin
              state_r <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_result_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          acc_r   <= {A{1'b0}};
          count_r <= LEN_ZERO;
          sat_r   <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; result fields are zero outside HOLD.
  assign o_busy         = (state_r != ST_IDLE);
  assign o_ready        = (state_r == ST_ACCUM);
  assign o_result_valid = (state_r == ST_HOLD);
  assign o_result       = (state_r == ST_HOLD) ? acc_r : {A{1'b0}};
  assign o_sat          = (state_r == ST_HOLD) ? sat_r : 1'b0;

endmodule

// File: tb/tb_sa_mac_seq.sv
// Directed self-checking bench for sa_mac_seq.
module tb_sa_mac_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_len;
  logic [15:0] i_bias;
  logic        o_busy;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_act;
  logic [7:0]  i_weight;
  logic [15:0] o_result;
  logic        o_result_valid;
  logic        i_result_ready;
  logic        o_sat;

  int n_checks;
  int n_pass;
  int act_v [256];
  int wgt_v [256];

  sa_mac_seq #(
    .MUL_DATAWIDTH (8),
    .ADD_DATAWIDTH (16),
    .LEN_WIDTH     (8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_len          (i_len),
    .i_bias         (i_bias),
    .o_busy         (o_busy),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_act          (i_act),
    .i_weight       (i_weight),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_sat          (o_sat)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int res();
    return int'($signed(o_result));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " busy"},  int'(o_busy), 0);
    check({tag, " ready"}, int'(o_ready), 0);
    check({tag, " rv"},    int'(o_result_valid), 0);
    check({tag, " res"},   res(), 0);
    check({tag, " sat"},   int'(o_sat), 0);
  endtask

  // Full operation: start, stream len pairs from act_v/wgt_v, check result,
  // then handshake with a (to be ignored) start pulse in the same cycle.
  task automatic run_op(input int len, input int bias, input int exp_res,
                        input int exp_sat, input string tag);
    i_start = 1'b1;
    i_len   = len[7:0];
    i_bias  = bias[15:0];
    @(negedge i_clk);
    i_start = 1'b0;
    i_len   = 8'd3;
    i_bias  = 16'h1234;
    for (int k = 0; k < len; k++) begin
      check({tag, " ready"}, int'(o_ready), 1);
      i_valid  = 1'b1;
      i_act    = act_v[k][7:0];
      i_weight = wgt_v[k][7:0];
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    check({tag, " rv"},       int'(o_result_valid), 1);
    check({tag, " res"},      res(), exp_res);
    check({tag, " sat"},      int'(o_sat), exp_sat);
    check({tag, " hold rdy"}, int'(o_ready), 0);
    i_result_ready = 1'b1;
    i_start        = 1'b1;
    i_len          = 8'd0;
    @(negedge i_clk);
    i_result_ready = 1'b0;
    i_start        = 1'b0;
    check({tag, " post busy"}, int'(o_busy), 0);
    check({tag, " post rv"},   int'(o_result_valid), 0);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    i_rst          = 1'b1;
    i_start        = 1'b1;
    i_len          = 8'd0;
    i_bias         = 16'd0;
    i_valid        = 1'b0;
    i_act          = 8'd0;
    i_weight       = 8'd0;
    i_result_ready = 1'b0;

    // Reset for two cycles with random inputs and start held high.
    for (int c = 0; c < 2; c++) begin
      i_start        = 1'b1;
      i_len          = 8'($urandom);
      i_bias         = 16'($urandom);
      i_valid        = 1'($urandom);
      i_act          = 8'($urandom);
      i_weight       = 8'($urandom);
      i_result_ready = 1'($urandom);
      @(negedge i_clk);
    end
    check_idle("reset");
    i_rst          = 1'b0;
    i_start        = 1'b0;
    i_valid        = 1'b0;
    i_result_ready = 1'b0;
    @(negedge i_clk);
    check_idle("after reset");

    // Basic dot product with cycle-exact latency checks.
    i_start = 1'b1; i_len = 8'd3; i_bias = 16'd0;
    @(negedge i_clk);
    i_start = 1'b0;
    check("basic c1 busy", int'(o_busy), 1);
    check("basic c1 ready", int'(o_ready), 1);
    i_valid = 1'b1; i_act = 8'd2; i_weight = 8'd3;
    @(negedge i_clk);
    i_act = 8'd4; i_weight = 8'hFF;
    @(negedge i_clk);
    check("basic c3 rv", int'(o_result_valid), 0);
    i_act = 8'hFB; i_weight = 8'd2;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("basic c4 rv", int'(o_result_valid), 1);
    check("basic res", res(), -8);
    check("basic sat", int'(o_sat), 0);
    i_result_ready = 1'b1; i_start = 1'b1; i_len = 8'd0;
    @(negedge i_clk);
    i_result_ready = 1'b0; i_start = 1'b0;
    check("basic post busy", int'(o_busy), 0);
    check("basic post rv", int'(o_result_valid), 0);

    // Product clamp in both directions.
    act_v[0] = 127;  wgt_v[0] = 2;
    run_op(1, 0, 127, 1, "pclamp pos");
    act_v[0] = -128; wgt_v[0] = -128;
    run_op(1, 0, 127, 1, "pclamp negneg");

    // Add clamp at the top and bottom of the accumulator range.
    act_v[0] = 10;  wgt_v[0] = 10;
    run_op(1, 32760, 32767, 1, "aclamp hi");
    act_v[0] = -10; wgt_v[0] = 10;
    run_op(1, -32760, -32768, 1, "aclamp lo");

    // Zero length with result backpressure; sat must be cleared by start.
    i_start = 1'b1; i_len = 8'd0; i_bias = 16'hFFF9;
    @(negedge i_clk);
    i_start = 1'b0; i_bias = 16'd55;
    for (int c = 0; c < 5; c++) begin
      check("zlen rv", int'(o_result_valid), 1);
      check("zlen res", res(), -7);
      check("zlen sat", int'(o_sat), 0);
      check("zlen busy", int'(o_busy), 1);
      @(negedge i_clk);
    end
    i_result_ready = 1'b1;
    @(negedge i_clk);
    i_result_ready = 1'b0;
    check("zlen post busy", int'(o_busy), 0);

    // Stalls between pairs and ignored start pulses during ACCUM.
    i_start = 1'b1; i_len = 8'd4; i_bias = 16'd10;
    @(negedge i_clk);
    i_start = 1'b0;
    i_valid = 1'b1; i_act = 8'd1; i_weight = 8'd1;
    @(negedge i_clk);
    i_valid = 1'b0; i_act = 8'd100; i_weight = 8'd100;
    i_start = 1'b1; i_len = 8'd1; i_bias = 16'd999;
    @(negedge i_clk);
    i_start = 1'b0;
    i_valid = 1'b1; i_act = 8'd2; i_weight = 8'd3;
    @(negedge i_clk);
    i_valid = 1'b0; i_act = 8'd50; i_weight = 8'd50; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("stall no early rv", int'(o_result_valid), 0);
    check("stall ready", int'(o_ready), 1);
    i_valid = 1'b1; i_act = 8'hFC; i_weight = 8'd5;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("stall 3 pairs rv", int'(o_result_valid), 0);
    @(negedge i_clk);
    i_valid = 1'b1; i_act = 8'd6; i_weight = 8'hFF;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("stall rv", int'(o_result_valid), 1);
    check("stall res", res(), -9);
    check("stall sat", int'(o_sat), 0);
    i_result_ready = 1'b1;
    @(negedge i_clk);
    i_result_ready = 1'b0;
    check("stall post busy", int'(o_busy), 0);

    // Reset in the middle of an operation, then a fresh operation.
    i_start = 1'b1; i_len = 8'd4; i_bias = 16'd100;
    @(negedge i_clk);
    i_start = 1'b0;
    i_valid = 1'b1; i_act = 8'd3; i_weight = 8'd3;
    @(negedge i_clk);
    i_act = 8'd2; i_weight = 8'd2;
    @(negedge i_clk);
    i_rst = 1'b1; i_act = 8'd5; i_weight = 8'd5; i_result_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_result_ready = 1'b0;
    check_idle("midrst");
    for (int c = 0; c < 3; c++) @(negedge i_clk);
    i_valid = 1'b0;
    check("midrst later rv", int'(o_result_valid), 0);
    check("midrst later busy", int'(o_busy), 0);
    act_v[0] = 3; wgt_v[0] = -4;
    run_op(1, 5, -7, 0, "after midrst");

    // Maximum length: 255 pairs of (1,1) on bias -100.
    for (int k = 0; k < 255; k++) begin
      act_v[k] = 1;
      wgt_v[k] = 1;
    end
    run_op(255, -100, 155, 0, "maxlen");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sa_mac_seq.md
# sa_mac_seq

Sequencer that time-shares a single saturating signed MAC (instantiated internally) to compute a length-N dot product with bias: result = sat(bias + Σ sat(act_i·weight_i)). Each step's product and each partial sum are clamped. Operands arrive as a valid/ready stream. The result leaves through a valid/ready output port. It sits between an operand fetch/streaming front end and the writeback path. It is the scalar reference engine and fallback path alongside the systolic array.

## Interface
Parameters:
- MUL_DATAWIDTH, 8, signed width of act, weight and the clamped product.
- ADD_DATAWIDTH, 16, signed width of bias, accumulator and result.
- LEN_WIDTH, 8, width of the dot-product length field.

Ports:
- i_clk  input  1  clock. One clock domain; everything is sampled on the rising edge.
- i_rst  input  1  reset. Synchronous, active-high.
- i_start  input  1  start request. Sampled only in IDLE.
- i_len  input  LEN_WIDTH  number of pairs, unsigned. Latched on an accepted start.
- i_bias  input  ADD_DATAWIDTH  initial partial sum, signed. Latched on an accepted start.
- o_busy  output  1  high whenever state != IDLE.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  operand pair accepted when i_valid && o_ready.
- i_act  input  MUL_DATAWIDTH  signed activation.
- i_weight  input  MUL_DATAWIDTH  signed weight.
- o_result  output  ADD_DATAWIDTH  signed dot-product result.
- o_result_valid  output  1  result valid.
- i_result_ready  input  1  downstream accepts the result.
- o_sat  output  1  high if any product or add clamp occurred during this operation. Valid alongside o_result.

## Operation
- States:
  - IDLE: waits for i_start.
  - ACCUM: consumes operand pairs.
  - HOLD: presents the result.
- IDLE behaviour:
  - On i_start: latch i_len into the remaining count, load acc ← i_bias and clear the sat flag.
  - Next state is ACCUM if i_len != 0, otherwise HOLD.
- ACCUM behaviour:
  - o_ready = 1.
  - On each accepted pair: acc ← mac(i_act, i_weight, acc) and count ← count − 1.
  - Set the sat flag if that step clamped.
  - After the last pair (count was 1), next state is HOLD.
  - Cycles with i_valid = 0 leave all state unchanged.
- MAC arithmetic:
  - The full 2·MUL_DATAWIDTH-bit signed product is clamped to [−2^(MUL−1), 2^(MUL−1)−1].
  - The clamped product is added to acc with one bit of headroom.
  - The sum is clamped to [−2^(ADD−1), 2^(ADD−1)−1].
  - A step "clamped" if either stage clamped. The sequencer computes this itself.
- HOLD behaviour:
  - o_result_valid = 1, o_result = acc, o_sat = the sat flag.
  - On i_result_ready, next state is IDLE.
- Input rules:
  - i_start in ACCUM or HOLD is ignored.
  - Changes to i_len or i_bias after start is accepted have no effect.
  - No operand is accepted outside ACCUM (o_ready = 0).
- Reset:
  - i_rst in any state aborts the operation and produces no result.
  - Next state is IDLE with acc, count and sat cleared.
  - i_rst has priority over every other input.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset values: o_busy = 0, o_ready = 0, o_result_valid = 0, o_result = 0, o_sat = 0.
- Latency with i_start at cycle 0 and i_valid held high:
  - o_ready is high in cycles 1..N.
  - o_result_valid rises in cycle N+1.
- Latency with len = 0: o_result_valid rises in cycle 1 and o_result = bias.
- Result hold: o_result, o_sat and o_result_valid stay stable until the handshake cycle. o_busy falls the cycle after the handshake.
- Back-to-back operations: the earliest next start is the first IDLE cycle. i_start in the handshake cycle is ignored.
- Throughput: one pair per cycle. Minimum operation period is N+2 cycles (start, N pairs, one-cycle HOLD with ready high).
- Maximum length: len = 2^LEN_WIDTH − 1 is supported. The count never wraps.

## Test plan
- Reset: assert i_rst for 2 cycles with random inputs, including i_start = 1 → all outputs 0 and state IDLE after release.
- Basic dot product:
  - Stimulus: len = 3, bias = 0, pairs (2,3), (4,−1), (−5,2) streamed back-to-back.
  - Response: o_result = −8, o_sat = 0, o_result_valid first high 4 cycles after start.
- Product clamp:
  - Stimulus: len = 1, bias = 0, pair (127,2).
  - Response: o_result = 127, o_sat = 1. Then len = 1, pair (−128,−128) → 127, o_sat = 1.
- Add clamp:
  - Stimulus: bias = 32760, pair (10,10); then bias = −32760, pair (−10,10).
  - Response: first result 32767, second result −32768, o_sat = 1 in both.
- Zero length and backpressure:
  - Stimulus: len = 0, bias = −7, i_result_ready held low 5 cycles.
  - Response: o_result = −7 from cycle 1, stable for 5 cycles. o_busy falls the cycle after ready rises.
- Stalls, ignored start and mid-operation reset:
  - len = 4 with i_valid gaps: pairs are counted only on handshakes.
  - i_start pulses during ACCUM are ignored.
  - i_rst after 2 pairs: no o_result_valid, IDLE, outputs 0. A fresh len = 1 op then computes correctly from its new bias.
